inverter_stim_checker: RTL and testbench



---
 rtl/inverter_test_pkg.sv | 17 +
 rtl/bit_synchronizer.sv | 23 ++
 rtl/inverter_stim_checker.sv | 165 ++++++++++++++++
 tb/tb_inverter_stim_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/inverter_test_pkg.sv
// rtl/inverter_test_pkg.sv - shared state encoding and default sizing for the inverter stimulus checker
package inverter_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        TOGGLE,
        WAIT,
        DONE
    } state_e;

    localparam int DEF_NUM_TOGGLES = 16;
    localparam int DEF_TIMEOUT     = 255;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - multi-flop synchronizer for one asynchronous bit
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/inverter_stim_checker.sv
// rtl/inverter_stim_checker.sv - drives the inverter input, times each response and counts errors
module inverter_stim_checker
    import inverter_test_pkg::*;
#(
    parameter int NUM_TOGGLES = DEF_NUM_TOGGLES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_in,
    output logic             stim_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout_flag,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] max_latency
);

    localparam int TW = $clog2(NUM_TOGGLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] SYNC_C    = CNT_W'(SYNC_STAGES);
    localparam logic [TW-1:0]    NUM_C     = TW'(NUM_TOGGLES);

    state_e           state_q, state_d;
    logic             stim_q, stim_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [TW-1:0]    tog_q, tog_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             tflag_q, tflag_d;
    logic             pass_q, pass_d;
    logic             resp_s;
    logic             resp_match;
    logic             err_inc;
    state_e           after_wait;

    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_resp_sync (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (resp_in),
        .q_o  (resp_s)
    );

    assign resp_match = (resp_s == ~stim_q);
    assign after_wait = (tog_q < NUM_C) ? TOGGLE : DONE;

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        lat_d   = lat_q;
        tog_d   = tog_q;
        err_d   = err_q;
        last_d  = last_q;
        max_d   = max_q;
        tflag_d = tflag_q;
        pass_d  = pass_q;
        err_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d   = '0;
                    max_d   = '0;
                    last_d  = '0;
                    tflag_d = 1'b0;
                    pass_d  = 1'b0;
                    tog_d   = '0;
                    lat_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (resp_match) begin
                    state_d = TOGGLE;
                end else if (lat_q == TIMEOUT_C) begin
                    err_inc = 1'b1;
                    tflag_d = 1'b1;
                    state_d = TOGGLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            TOGGLE: begin
                stim_d  = ~stim_q;
                lat_d   = '0;
                tog_d   = tog_q + 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // a match before the synchronizer could have seen the new level is stale
                if (resp_match) begin
                    last_d  = lat_q;
                    err_inc = (lat_q < SYNC_C);
                    state_d = after_wait;
                end else if (lat_q == TIMEOUT_C) begin
                    last_d  = TIMEOUT_C;
                    err_inc = 1'b1;
                    tflag_d = 1'b1;
                    state_d = after_wait;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
                if (state_d != WAIT && last_d > max_q) begin
                    max_d = last_d;
                end
            end
            DONE: begin
                stim_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_inc && err_q != '1) begin
            err_d = err_q + 1'b1;
        end
        if (state_q == WAIT && state_d == DONE) begin
            pass_d = (err_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stim_q  <= 1'b0;
            lat_q   <= '0;
            tog_q   <= '0;
            err_q   <= '0;
            last_q  <= '0;
            max_q   <= '0;
            tflag_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            lat_q   <= lat_d;
            tog_q   <= tog_d;
            err_q   <= err_d;
            last_q  <= last_d;
            max_q   <= max_d;
            tflag_q <= tflag_d;
            pass_q  <= pass_d;
        end
    end

    assign stim_out     = stim_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign pass         = pass_q;
    assign timeout_flag = tflag_q;
    assign err_count    = err_q;
    assign last_latency = last_q;
    assign max_latency  = max_q;

endmodule

// File: tb/tb_inverter_stim_checker.sv
// tb/tb_inverter_stim_checker.sv - randomized bench with a delay-line reference model
module tb_inverter_stim_checker;

    localparam int NT   = 4;
    localparam int TMO  = 20;
    localparam int SYNC = 2;
    localparam int W    = 8;
    localparam int TMO2 = 3;
    localparam int W2   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          resp_in = 1'b1;
    logic          stim_out, busy, done, pass, timeout_flag;
    logic [W-1:0]  err_count, last_latency, max_latency;

    logic          start2 = 1'b0;
    logic          resp2 = 1'b0;
    logic          stim2, busy2, done2, pass2, tflag2;
    logic [W2-1:0] err2, last2, max2;

    int            n_tests = 0;
    int            n_fail = 0;
    int            delay_v = 0;
    int            stuck_v = -1;
    logic [63:0]   hist_v = '0;

    logic          model_stim [0:4095];
    int            m_err, m_last, m_max, m_tflag, m_len;

    always #5 clk = ~clk;

    inverter_stim_checker #(
        .NUM_TOGGLES(NT), .TIMEOUT(TMO), .SYNC_STAGES(SYNC), .CNT_W(W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .resp_in(resp_in),
        .stim_out(stim_out), .busy(busy), .done(done), .pass(pass),
        .timeout_flag(timeout_flag), .err_count(err_count),
        .last_latency(last_latency), .max_latency(max_latency)
    );

    inverter_stim_checker #(
        .NUM_TOGGLES(NT), .TIMEOUT(TMO2), .SYNC_STAGES(SYNC), .CNT_W(W2)
    ) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .resp_in(resp2),
        .stim_out(stim2), .busy(busy2), .done(done2), .pass(pass2),
        .timeout_flag(tflag2), .err_count(err2),
        .last_latency(last2), .max_latency(max2)
    );

    // inverter macro: transport delay of delay_v cycles, or stuck at a level
    always @(posedge clk) begin
        #1;
        hist_v = {hist_v[62:0], stim_out};
        if (stuck_v >= 0) resp_in = stuck_v[0];
        else              resp_in = ~hist_v[delay_v];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic model_resp(input int t, input int d, input int stuck);
        int idx;
        idx = t - d - SYNC;
        if (stuck >= 0) return stuck[0];
        if (idx < 0)    return 1'b1;
        return ~model_stim[idx];
    endfunction

    // cycle 0 is the first cycle after start is accepted; stimulus was low long before it
    task automatic model_run(input int d, input int stuck, input int nt, input int tmo);
        int   t, k;
        logic cur, fin;
        m_err = 0; m_last = 0; m_max = 0; m_tflag = 0;
        cur = 1'b0; t = 0; fin = 1'b0;
        while (!fin) begin
            model_stim[t] = cur;
            if (model_resp(t, d, stuck) == ~cur) fin = 1'b1;
            else if (t == tmo) begin m_err++; m_tflag = 1; fin = 1'b1; end
            else t++;
        end
        t++;
        for (int i = 0; i < nt; i++) begin
            model_stim[t] = cur;
            cur = ~cur;
            t++;
            k = 0; fin = 1'b0;
            while (!fin) begin
                model_stim[t] = cur;
                if (model_resp(t, d, stuck) == ~cur) begin
                    m_last = k; if (k < SYNC) m_err++; fin = 1'b1;
                end else if (k == tmo) begin
                    m_last = tmo; m_err++; m_tflag = 1; fin = 1'b1;
                end else begin
                    k++; t++;
                end
            end
            if (m_last > m_max) m_max = m_last;
            t++;
        end
        m_len = t;
    endtask

    task automatic set_mode(input int d, input int stuck);
        delay_v = d;
        stuck_v = stuck;
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic launch(input bit hold);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic follow_run(input int d, input int stuck, input string tag);
        int   c, toggles, nonbusy, exp_err;
        logic prev;
        model_run(d, stuck, NT, TMO);
        exp_err = (m_err > 255) ? 255 : m_err;
        c = 0; toggles = 0; nonbusy = 0; prev = 1'b0;
        while (!done && c < 3000) begin
            if (!busy) nonbusy++;
            if (stim_out !== prev) toggles++;
            prev = stim_out;
            @(posedge clk); #1;
            c++;
        end
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_len"}, c, m_len);
        check_eq({tag, "_busy"}, nonbusy, 0);
        @(posedge clk); #1;
        check_eq({tag, "_done_once"}, done, 0);
        check_eq({tag, "_idle"}, busy, 0);
        check_eq({tag, "_stim0"}, stim_out, 0);
        check_eq({tag, "_toggles"}, toggles, NT);
        check_eq({tag, "_err"}, err_count, exp_err);
        check_eq({tag, "_last"}, last_latency, m_last);
        check_eq({tag, "_max"}, max_latency, m_max);
        check_eq({tag, "_max_bound"}, max_latency <= TMO, 1);
        check_eq({tag, "_tflag"}, timeout_flag, m_tflag);
        check_eq({tag, "_pass"}, pass, m_err == 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_stim"}, stim_out, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_tflag"}, timeout_flag, 0);
        check_eq({tag, "_err"}, err_count, 0);
        check_eq({tag, "_last"}, last_latency, 0);
        check_eq({tag, "_max"}, max_latency, 0);
    endtask

    initial begin
        int dones, c, d, s;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        set_mode(0, -1);  launch(0); follow_run(0, -1, "ideal");
        set_mode(5, -1);  launch(0); follow_run(5, -1, "delay5");
        set_mode(0, 0);   launch(0); follow_run(0, 0, "stuck0");

        set_mode(0, 1);   launch(0);
        dones = 0;
        repeat (10) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        check_eq("midrun_busy", busy, 1);
        check_eq("midrun_stim", stim_out, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("midrun_rst");
        rst = 1'b0;
        repeat (3) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        check_eq("midrun_no_done", dones, 0);
        set_mode(2, -1);  launch(0); follow_run(2, -1, "after_rst");

        set_mode(3, -1);  launch(1); follow_run(3, -1, "hold_run1");
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("hold_restart_busy", busy, 1);
        check_eq("hold_clear_max", max_latency, 0);
        check_eq("hold_clear_last", last_latency, 0);
        check_eq("hold_clear_pass", pass, 0);
        follow_run(3, -1, "hold_run2");

        set_mode(TMO + 10, -1); launch(0); follow_run(TMO + 10, -1, "slow");

        for (int i = 0; i < 12; i++) begin
            s = $urandom_range(0, 9);
            d = $urandom_range(0, TMO + 12);
            if (s >= 2) s = -1;
            set_mode(d, s); launch(0); follow_run(d, s, $sformatf("rand%0d", i));
        end

        model_run(0, 0, NT, TMO2);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        c = 0;
        while (!done2 && c < 500) begin
            @(posedge clk); #1;
            c++;
        end
        check_eq("sat_len", c, m_len);
        @(posedge clk); #1;
        check_eq("sat_err", err2, (m_err > 3) ? 3 : m_err);
        check_eq("sat_last", last2, m_last);
        check_eq("sat_max", max2, m_max);
        check_eq("sat_tflag", tflag2, m_tflag);
        check_eq("sat_pass", pass2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
